subbytes_iter: RTL and testbench
================================

Name: subbytes_iter

Overview:
- Iterative AES SubBytes stage with a valid/ready handshake.
- Sits directly upstream of the ShiftRows combinational stage in the chaos crypto engine round datapath. It substitutes all 16 state bytes through LANES S-box instances over 16/LANES cycles.
- The registered result is presented to ShiftRows and held until the consumer accepts it.
- Trades area against throughput: 4 lanes by default instead of 16 S-boxes.

Parameters:
- LANES, 4, number of S-box instances and bytes substituted per cycle. Legal values: 1, 2, 4, 8, 16. Any other value causes an elaboration error.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream presents a state in in_data.
- in_ready  out  1  block can accept a state this cycle.
- in_data  in  128  input state; byte i is at [127-8i -: 8], i = 0..15, column-major (byte 0 = row0/col0).
- out_valid  out  1  out_data holds a substituted state.
- out_ready  in  1  downstream consumes out_data.
- out_data  out  128  substituted state, same byte layout as in_data; feeds ShiftRows directly.

Behaviour:
- N = 16/LANES beats per block.
- Internal registers:
  - state: IDLE, BUSY or DONE.
  - beat counter, ceil(log2 N) bits, minimum 1 bit.
  - 128-bit work register.
- Reset (async assert, sync release): state = IDLE, counter = 0, work register = 0, out_valid = 0, out_data = 0, in_ready = 1 after release.
- in_ready = (state==IDLE) | (state==DONE & out_ready). This is a combinational path from out_ready to in_ready, and it is intentional.
- Accept: the handshake is in_valid & in_ready at a rising edge. On accept, the work register loads in_data, the counter clears, and state goes to BUSY.
- BUSY, beat k (0..N-1):
  - Bytes k*LANES .. k*LANES+LANES-1 of the work register are replaced by their S-box images in place; most-significant bytes are processed first.
  - Counter increments. At k = N-1 the counter wraps to 0 and state goes to DONE.
- DONE:
  - out_valid = 1 and out_data = work register; both are stable while out_ready = 0.
  - out_ready = 1 with in_valid = 0: state goes to IDLE and out_valid drops the next cycle.
  - out_ready = 1 with in_valid = 1: a new state is accepted in the same edge and state goes directly to BUSY (back-to-back operation).
- Latency: out_valid rises N cycles after the accepting edge (LANES=4: 4 cycles; LANES=16: 1 cycle).
- Throughput: one block per N+1 cycles when out_ready is held high.
- in_valid is ignored while state is BUSY; in_data need not be held stable after accept.
- out_data is driven from the work register in all states. It is valid only while out_valid = 1.
- The S-box is a combinational ROM per lane (the FIPS-197 table) and is not registered. The critical path is one S-box lookup plus the work-register mux.
- Reset asserted mid-BUSY or mid-DONE: the block aborts immediately, the partial result is discarded, and all outputs take their reset values.

Optional Feature:
- Macro: SUBBYTES_INV_EN.
- Defined:
  - Adds input port `inv  in  1`, sampled only at the accepting edge and held internally for the block.
  - inv = 1 selects the inverse S-box (InvSubBytes) for all beats; inv = 0 selects the forward S-box.
  - Each lane instantiates both tables plus a 2:1 mux.
- Not defined: no inv port, forward S-box only, no inverse tables in the netlist.

Test Plan:
- FIPS-197 App. B round-1 vector, LANES=4, out_ready=1:
  - Stimulus: in_data = 193de3bea0f4e22b9ac68d2ae9f84808.
  - Response: out_data = d42711aee0bf98f1b8b45de51e415230, with out_valid rising exactly 4 cycles after accept.
- All-zero input:
  - Stimulus: in_data = 0.
  - Response: out_data = 63636363636363636363636363636363.
  - With SUBBYTES_INV_EN defined and inv=1, input = 63..63 gives out_data = 0.
- Backpressure:
  - Stimulus: out_ready = 0 for 10 cycles after out_valid rises.
  - Response: out_data stays stable, out_valid stays 1, in_ready = 0 throughout. Releasing out_ready together with a new in_valid accepts the next block in the same edge.
- Back-to-back: 8 random blocks with in_valid and out_ready held high → one result every 5 cycles, each matching a software reference model.
- Reset mid-operation:
  - Stimulus: rst pulsed during beat 2 of BUSY.
  - Response: out_valid = 0, out_data = 0, in_ready = 1 after release, and the next block completes correctly.
- Parameter sweep: LANES = 1, 2, 8, 16 with the App. B vector → identical out_data, with latencies of 16, 8, 2 and 1 cycles respectively.

Source files
------------

// File: rtl/subbytes_iter_if.sv
// Handshake bundle for subbytes_iter. The inv bit exists only when SUBBYTES_INV_EN is defined.
interface subbytes_iter_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
`ifdef SUBBYTES_INV_EN
    logic         inv;

    modport slave  (input  in_valid, in_data, out_ready, inv,
                    output in_ready, out_valid, out_data);
    modport master (output in_valid, in_data, out_ready, inv,
                    input  in_ready, out_valid, out_data);
`else
    modport slave  (input  in_valid, in_data, out_ready,
                    output in_ready, out_valid, out_data);
    modport master (output in_valid, in_data, out_ready,
                    input  in_ready, out_valid, out_data);
`endif
endinterface

// File: rtl/subbytes_iter.sv
// Iterative AES SubBytes: LANES S-boxes sweep the 16-byte state over 16/LANES beats.
// Define SUBBYTES_INV_EN to add the inv input and inverse S-box tables.
module subbytes_iter #(
    parameter int LANES = 4
) (
    input  logic           clk,
    input  logic           rst,
    subbytes_iter_if.slave bus
);
    localparam int N     = 16 / LANES;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam int LOG_L = $clog2(LANES);

    // Entry 0 in the top byte, so entry b lives at bit {~b, 3'b000}.
    localparam logic [2047:0] SBOX_FWD = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };
`ifdef SUBBYTES_INV_EN
    localparam logic [2047:0] SBOX_INV = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };
`endif

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
        $error("subbytes_iter: LANES must be 1, 2, 4, 8 or 16");
    end

    function automatic logic [7:0] sbox_fwd(input logic [7:0] b);
        return SBOX_FWD[{~b, 3'b000} +: 8];
    endfunction

`ifdef SUBBYTES_INV_EN
    function automatic logic [7:0] sbox_inv(input logic [7:0] b);
        return SBOX_INV[{~b, 3'b000} +: 8];
    endfunction
`endif

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       work_q    [16];
    logic [7:0]       work_d    [16];
    logic [7:0]       in_bytes  [16];
    logic [7:0]       sub_bytes [16];
    logic [7:0]       lane_in   [LANES];
    logic [7:0]       lane_out  [LANES];
    logic [3:0]       base;
    logic             accept;
`ifdef SUBBYTES_INV_EN
    logic             inv_q, inv_d;
`endif

    assign base = 4'(32'(cnt_q) << LOG_L);

    for (genvar gj = 0; gj < LANES; gj++) begin : g_lane
        assign lane_in[gj] = work_q[base + 4'(gj)];
`ifdef SUBBYTES_INV_EN
        assign lane_out[gj] = inv_q ? sbox_inv(lane_in[gj]) : sbox_fwd(lane_in[gj]);
`else
        assign lane_out[gj] = sbox_fwd(lane_in[gj]);
`endif
    end

    // Byte i always belongs to lane i%LANES on beat i/LANES, so the write-back mux has constant selects.
    for (genvar gi = 0; gi < 16; gi++) begin : g_byte
        assign in_bytes[gi]  = bus.in_data[127 - 8*gi -: 8];
        assign sub_bytes[gi] = (cnt_q == CNT_W'(gi / LANES)) ? lane_out[gi % LANES] : work_q[gi];
        assign bus.out_data[127 - 8*gi -: 8] = work_q[gi];
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        work_d        = work_q;
`ifdef SUBBYTES_INV_EN
        inv_d         = inv_q;
`endif
        bus.in_ready  = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
        bus.out_valid = (state_q == DONE);
        accept        = bus.in_valid && bus.in_ready;

        case (state_q)
            IDLE: ;
            BUSY: begin
                work_d = sub_bytes;
                if (cnt_q == CNT_W'(N - 1)) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Accept overrides the DONE drain so back-to-back blocks go straight to BUSY.
        if (accept) begin
            work_d  = in_bytes;
            cnt_d   = '0;
            state_d = BUSY;
`ifdef SUBBYTES_INV_EN
            inv_d   = bus.inv;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            work_q  <= '{default: '0};
`ifdef SUBBYTES_INV_EN
            inv_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
`ifdef SUBBYTES_INV_EN
            inv_q   <= inv_d;
`endif
        end
    end
endmodule

// File: tb/tb_subbytes_iter.sv
// Bench for subbytes_iter: one instance per legal LANES value sharing stimulus; checks use
// an S-box model computed from GF(2^8) inversion plus the affine map.
module tb_subbytes_iter;
    localparam int M = 2;  // index of the LANES=4 instance

    localparam logic [127:0] APPB_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] APPB_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         out_ready;
    logic [127:0] in_data;
`ifdef SUBBYTES_INV_EN
    logic         inv;
`endif
    logic         ir [5];
    logic         ov [5];
    logic [127:0] od [5];

    int checks   = 0;
    int failures = 0;

    logic [7:0]   fwd_tab [256];
    logic [7:0]   inv_tab [256];
    logic [127:0] exp_q [$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 5; g++) begin : g_dut
        subbytes_iter_if bus ();
        assign bus.in_valid  = in_valid;
        assign bus.in_data   = in_data;
        assign bus.out_ready = out_ready;
`ifdef SUBBYTES_INV_EN
        assign bus.inv       = inv;
`endif
        assign ir[g] = bus.in_ready;
        assign ov[g] = bus.out_valid;
        assign od[g] = bus.out_data;

        subbytes_iter #(.LANES(1 << g)) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );
    end

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = '0;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox_calc(input logic [7:0] a);
        logic [7:0] v;
        v = '0;
        for (int c = 1; c < 256; c++)
            if (gmul(a, 8'(c)) == 8'h01) v = 8'(c);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] model(input logic [127:0] d, input logic use_inv);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            r = {r[119:0], use_inv ? inv_tab[d[127:120]] : fwd_tab[d[127:120]]};
            d = d << 8;
        end
        return r;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        check(tag, {127'b0, obs}, {127'b0, exp});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [127:0] d);
        #1;
        check_bit("send_in_ready", ir[M], 1'b1);
        in_data  = d;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        in_data  = rnd128();
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!ov[M] && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    // Streams nblk blocks with in_valid/out_ready high; seq=1 walks all 256 byte values.
    task automatic run_stream(input int nblk, input logic seq, input logic use_inv);
        int cyc, last, nsent, nrecv;
        logic acc;
        logic [127:0] d;
        exp_q.delete();
        nsent = 0;
        nrecv = 0;
        cyc   = 0;
        last  = -1;
`ifdef SUBBYTES_INV_EN
        inv = use_inv;
`endif
        d = rnd128();
        if (seq) for (int i = 0; i < 16; i++) d = {d[119:0], 8'(i)};
        in_data   = d;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        while (nrecv < nblk && cyc < 400) begin
            #1;
            acc = in_valid && ir[M];
            if (ov[M]) begin
                check("stream_data", od[M], (exp_q.size() > 0) ? exp_q.pop_front() : 'x);
                if (last >= 0) check("stream_period", 128'(cyc - last), 128'(5));
                last = cyc;
                nrecv++;
            end
            tick();
            cyc++;
            if (acc) begin
                exp_q.push_back(model(in_data, use_inv));
                nsent++;
                if (nsent < nblk) begin
                    d = rnd128();
                    if (seq) for (int i = 0; i < 16; i++) d = {d[119:0], 8'(16 * nsent + i)};
                    in_data = d;
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        check("stream_count", 128'(nrecv), 128'(nblk));
`ifdef SUBBYTES_INV_EN
        inv = 1'b0;
`endif
    endtask

    initial begin
        int lat;
        logic [127:0] d, prev;
        int lats [5];

        for (int x = 0; x < 256; x++) fwd_tab[x] = sbox_calc(8'(x));
        for (int x = 0; x < 256; x++) inv_tab[fwd_tab[x]] = 8'(x);

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
`ifdef SUBBYTES_INV_EN
        inv       = 1'b0;
`endif
        tick();
        tick();
        check_bit("rst_out_valid", ov[M], 1'b0);
        check("rst_out_data", od[M], '0);
        check_bit("rst_in_ready", ir[M], 1'b1);
        rst = 1'b0;
        tick();
        check_bit("idle_in_ready", ir[M], 1'b1);
        check_bit("idle_out_valid", ov[M], 1'b0);

        // FIPS-197 App. B round-1 SubBytes
        out_ready = 1'b1;
        send(APPB_IN);
        wait_out(lat);
        check("appb_latency", 128'(lat), 128'(4));
        check("appb_data", od[M], APPB_OUT);
        check("appb_model", od[M], model(APPB_IN, 1'b0));
        check_bit("done_in_ready", ir[M], 1'b1);
        tick();
        check_bit("drain_out_valid", ov[M], 1'b0);

        send('0);
        wait_out(lat);
        check("zero_latency", 128'(lat), 128'(4));
        check("zero_data", od[M], {16{8'h63}});
        tick();

`ifdef SUBBYTES_INV_EN
        inv = 1'b1;
        send({16{8'h63}});
        inv = 1'b0;
        wait_out(lat);
        check("inv_zero_data", od[M], '0);
        tick();
        d   = rnd128();
        inv = 1'b1;
        send(d);
        inv = 1'b0;
        wait_out(lat);
        check("inv_rand_data", od[M], model(d, 1'b1));
        tick();
`endif

        // backpressure with a competing in_valid that must be ignored
        out_ready = 1'b0;
        d = rnd128();
        send(d);
        wait_out(lat);
        check("bp_latency", 128'(lat), 128'(4));
        prev     = model(d, 1'b0);
        in_valid = 1'b1;
        in_data  = rnd128();
        for (int c = 0; c < 10; c++) begin
            check("bp_data", od[M], prev);
            check_bit("bp_out_valid", ov[M], 1'b1);
            check_bit("bp_in_ready", ir[M], 1'b0);
            tick();
        end
        d         = rnd128();
        in_data   = d;
        out_ready = 1'b1;
        #1;
        check_bit("bp_release_ready", ir[M], 1'b1);
        check("bp_release_data", od[M], prev);
        tick();
        in_valid = 1'b0;
        check_bit("bp_next_busy", ov[M], 1'b0);
        check_bit("bp_next_in_ready", ir[M], 1'b0);
        wait_out(lat);
        check("bp_next_latency", 128'(lat), 128'(4));
        check("bp_next_data", od[M], model(d, 1'b0));
        tick();

        run_stream(8, 1'b0, 1'b0);
        run_stream(16, 1'b1, 1'b0);
`ifdef SUBBYTES_INV_EN
        run_stream(16, 1'b1, 1'b1);
`endif

        // reset during beat 2
        d = rnd128();
        send(d);
        tick();
        tick();
        rst = 1'b1;
        #1;
        check_bit("rst_busy_out_valid", ov[M], 1'b0);
        check("rst_busy_out_data", od[M], '0);
        check_bit("rst_busy_in_ready", ir[M], 1'b1);
        tick();
        rst = 1'b0;
        tick();
        check_bit("post_rst_out_valid", ov[M], 1'b0);
        check("post_rst_out_data", od[M], '0);
        check_bit("post_rst_in_ready", ir[M], 1'b1);
        d = rnd128();
        send(d);
        wait_out(lat);
        check("post_rst_latency", 128'(lat), 128'(4));
        check("post_rst_data", od[M], model(d, 1'b0));
        tick();

        // LANES sweep: all instances take the App. B vector on the same edge
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        for (int g = 0; g < 5; g++) lats[g] = 0;
        send(APPB_IN);
        for (int c = 1; c <= 20; c++) begin
            tick();
            for (int g = 0; g < 5; g++) begin
                if (ov[g] && lats[g] == 0) begin
                    lats[g] = c;
                    check($sformatf("sweep_data_L%0d", 1 << g), od[g], APPB_OUT);
                end
            end
        end
        for (int g = 0; g < 5; g++)
            check($sformatf("sweep_latency_L%0d", 1 << g), 128'(lats[g]), 128'(16 >> g));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
